// File: rtl/instruction_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch front end.
package instruction_fetch_unit_pkg;

  typedef logic [31:0] int_t;

  typedef struct packed {
    int_t pc;
    int_t word;
  } fetch_entry_t;

  localparam int_t RESET_PC_DEFAULT = 32'h0000_3000;
  localparam int_t PC_STEP          = 32'd4;

  function automatic int_t align_word(input int_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_fetch_queue.sv
// In-order circular FIFO of fetched {pc, word} entries; flush drops everything.
module fetch_queue
  import instruction_fetch_unit_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     push_entry,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Next-state for storage, pointers and occupancy; flush overrides push/pop.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      // When full, push and pop share the head slot: the old head is consumed this edge.
      if (push) begin
        mem_d[wr_ptr_q] = push_entry;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Queue state registers; storage is cleared on reset so the head reads as zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Front-end fetch: owns the PC, captures memory words into a fetch queue, honours redirects.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] imAddress,
  input  logic [31:0] imData,
  input  logic        imReady,
  input  logic        redirectValid,
  input  logic [31:0] redirectTarget,
  output logic        outValid,
  output logic [31:0] outPc,
  output logic [31:0] outInstruction,
  input  logic        outReady
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);

  int_t             fetch_pc_q, fetch_pc_d;
  logic [CNT_W-1:0] count_s;
  fetch_entry_t     head_s;
  fetch_entry_t     push_entry_s;
  logic             out_valid_s;
  logic             pop_s;
  logic             push_s;

  assign out_valid_s  = (count_s != '0);
  assign pop_s        = out_valid_s && outReady;
  assign push_s       = imReady && !redirectValid &&
                        ((count_s < CNT_W'(QUEUE_DEPTH)) || pop_s);
  assign push_entry_s = {fetch_pc_q, imData};

  // Redirect beats fetch; otherwise the PC advances only on a captured word.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirectValid) begin
      fetch_pc_d = align_word(redirectTarget);
    end else if (push_s) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end else begin
      fetch_pc_d = fetch_pc_q;
    end
  end

  // Fetch PC register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_fetch_queue (
    .clock      (clock),
    .reset      (reset),
    .push       (push_s),
    .pop        (pop_s),
    .flush      (redirectValid),
    .push_entry (push_entry_s),
    .head       (head_s),
    .count      (count_s)
  );

  assign imAddress      = fetch_pc_q;
  assign outValid       = out_valid_s;
  assign outPc          = head_s.pc;
  assign outInstruction = head_s.word;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a queue-based reference model.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_3000;
  localparam int          DEPTH  = 2;

  logic        clock;
  logic        reset;
  logic [31:0] imAddress;
  logic [31:0] imData;
  logic        imReady;
  logic        redirectValid;
  logic [31:0] redirectTarget;
  logic        outValid;
  logic [31:0] outPc;
  logic [31:0] outInstruction;
  logic        outReady;

  instruction_fetch_unit dut (
    .clock          (clock),
    .reset          (reset),
    .imAddress      (imAddress),
    .imData         (imData),
    .imReady        (imReady),
    .redirectValid  (redirectValid),
    .redirectTarget (redirectTarget),
    .outValid       (outValid),
    .outPc          (outPc),
    .outInstruction (outInstruction),
    .outReady       (outReady)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  assign imData = imReady ? mem_word(imAddress) : 32'hDEAD_BEEF;

  // Reference model: fetch PC plus an ordered list of captured (pc, word) pairs.
  logic [31:0] m_pc;
  logic [31:0] m_qpc[$];
  logic [31:0] m_qword[$];

  int errors = 0;
  int checks = 0;

  bit          pin_en    = 1'b0;
  bit          pin_valid = 1'b0;
  logic [31:0] pin_pc    = 32'h0;
  logic [31:0] pin_addr  = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clock) begin
    bit do_pop;
    bit do_push;
    if (!reset) begin
      m_pc = RST_PC;
      m_qpc.delete();
      m_qword.delete();
    end else begin
      do_pop = (m_qpc.size() != 0) && outReady;
      if (redirectValid) begin
        m_qpc.delete();
        m_qword.delete();
        m_pc = redirectTarget & 32'hFFFF_FFFC;
      end else begin
        do_push = imReady && ((m_qpc.size() < DEPTH) || do_pop);
        if (do_pop) begin
          void'(m_qpc.pop_front());
          void'(m_qword.pop_front());
        end
        if (do_push) begin
          m_qpc.push_back(m_pc);
          m_qword.push_back(mem_word(m_pc));
          m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Single compare process: reset state on reset assertion, model and pins otherwise.
  always begin
    @(negedge clock or negedge reset);
    if (!reset) begin
      #1;
      chk("rst_imAddress", imAddress, RST_PC);
      chk("rst_outValid", 32'(outValid), 32'd0);
      chk("rst_outPc", outPc, 32'd0);
      chk("rst_outInstruction", outInstruction, 32'd0);
    end else begin
      chk("imAddress", imAddress, m_pc);
      chk("outValid", 32'(outValid), 32'(m_qpc.size() != 0));
      if (m_qpc.size() != 0) begin
        chk("outPc", outPc, m_qpc[0]);
        chk("outInstruction", outInstruction, m_qword[0]);
      end
      if (pin_en) begin
        chk("pin_imAddress", imAddress, pin_addr);
        chk("pin_outValid", 32'(outValid), 32'(pin_valid));
        if (pin_valid) begin
          chk("pin_outPc", outPc, pin_pc);
          chk("pin_outInstruction", outInstruction, pin_pc ^ 32'hA5A5_0000);
        end
      end
    end
  end

  // One cycle: inputs already driven; optional literal expectation at the next negedge.
  task automatic cyc(input bit pe, input bit pv, input logic [31:0] ppc, input logic [31:0] paddr);
    pin_en    = pe;
    pin_valid = pv;
    pin_pc    = ppc;
    pin_addr  = paddr;
    @(negedge clock);
    #1;
    pin_en = 1'b0;
  endtask

  initial begin
    reset          = 1'b0;
    imReady        = 1'b0;
    outReady       = 1'b0;
    redirectValid  = 1'b0;
    redirectTarget = 32'h0;
    repeat (2) @(negedge clock);
    #1;

    // Streaming from reset.
    imReady  = 1'b1;
    outReady = 1'b1;
    reset    = 1'b1;
    cyc(1'b1, 1'b1, 32'h3000, 32'h3004);
    cyc(1'b1, 1'b1, 32'h3004, 32'h3008);
    cyc(1'b1, 1'b1, 32'h3008, 32'h300C);

    // Back-pressure from a fresh reset.
    reset = 1'b0;
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    outReady = 1'b0;
    reset    = 1'b1;
    repeat (4) cyc(1'b0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b1, 32'h3000, 32'h3008);
    outReady = 1'b1;
    cyc(1'b1, 1'b1, 32'h3004, 32'h300C);
    cyc(1'b1, 1'b1, 32'h3008, 32'h3010);

    // Redirect while full.
    outReady = 1'b0;
    cyc(1'b1, 1'b1, 32'h3008, 32'h3010);
    redirectValid  = 1'b1;
    redirectTarget = 32'h0000_3101;
    cyc(1'b1, 1'b0, 32'h0, 32'h3100);
    redirectValid = 1'b0;
    outReady      = 1'b1;
    cyc(1'b1, 1'b1, 32'h3100, 32'h3104);

    // Memory stall: queue drains, PC holds, fetch resumes.
    imReady = 1'b0;
    cyc(1'b1, 1'b0, 32'h0, 32'h3104);
    cyc(1'b1, 1'b0, 32'h0, 32'h3104);
    cyc(1'b1, 1'b0, 32'h0, 32'h3104);
    imReady = 1'b1;
    cyc(1'b1, 1'b1, 32'h3104, 32'h3108);

    // Wrap at the top of the address space.
    redirectValid  = 1'b1;
    redirectTarget = 32'hFFFF_FFFC;
    cyc(1'b1, 1'b0, 32'h0, 32'hFFFF_FFFC);
    redirectValid = 1'b0;
    cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0000);
    cyc(1'b1, 1'b1, 32'h0000_0000, 32'h0000_0004);

    // Reset asserted between edges while streaming.
    #2;
    reset = 1'b0;
    cyc(1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b1;
    cyc(1'b1, 1'b1, 32'h3000, 32'h3004);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      imReady       = ($urandom_range(0, 3) != 0);
      outReady      = ($urandom_range(0, 9) < 7);
      redirectValid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) begin
        redirectTarget = 32'hFFFF_FFF0 | ($urandom & 32'h0000_000F);
      end else begin
        redirectTarget = $urandom;
      end
      if ($urandom_range(0, 499) == 0) begin
        #2;
        reset = 1'b0;
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
        reset = 1'b1;
      end else begin
        cyc(1'b0, 1'b0, 32'h0, 32'h0);
      end
    end

    @(negedge clock);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Owns the program counter and sequences the instruction memory for the pipeline front end. Each cycle the unit presents the current fetch address to the instruction memory and captures the returned word into a small in-order fetch queue. The queue decouples memory availability from decode back-pressure. The unit delivers `{pc, word}` pairs to decode over a valid/ready handshake and honours branch/jump redirects from later stages by flushing the queue and reloading the PC. Decoding of the raw word (`parseInstruction`) stays downstream.

## Interface
- `RESET_PC`, default `32'h0000_3000`: fetch address after reset; low 2 bits are 0.
- `QUEUE_DEPTH`, default `2`: fetch-queue entries; must be at least 2.

- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = in reset).
- `imAddress`  out  32  fetch address to instruction memory; word-aligned.
- `imData`  in  32  raw word at `imAddress`, combinational from memory.
- `imReady`  in  1  `imData` is valid this cycle; when 0, no capture.
- `redirectValid`  in  1  redirect request from execute.
- `redirectTarget`  in  32  new fetch address; bits [1:0] are ignored and forced to 0.
- `outValid`  out  1  queue head is valid.
- `outPc`  out  32  PC of the queue head.
- `outInstruction`  out  32  raw word of the queue head.
- `outReady`  in  1  decode accepts the head this cycle.

## Operation
- State:
  - `fetchPc`, 32 bits.
  - Queue of `QUEUE_DEPTH` entries `{pc, word}`, with read pointer, write pointer and count.
- Combinational outputs:
  - `imAddress = fetchPc`.
  - `outValid = (count != 0)`.
  - `outPc` and `outInstruction` come from the head entry.
  - Neither `outValid` nor the head fields depend combinationally on `redirectValid` or `outReady`.
- Pop: `outValid && outReady`.
- Push (fetch fire): `imReady && !redirectValid && (count < QUEUE_DEPTH || pop)`.
  - Enqueues `{fetchPc, imData}`.
  - `fetchPc <= fetchPc + 4`, wrapping modulo 2^32 (`32'hFFFF_FFFC` → `0`).
- Redirect: highest priority.
  - `fetchPc <= {redirectTarget[31:2], 2'b00}`.
  - count and both pointers cleared to 0.
  - No push that cycle.
  - A pop handshake in the same cycle is treated as consumed; the entry is discarded by the flush regardless.
- Simultaneous push and pop with the queue full: allowed; count unchanged; no loss, no duplication.
- `imReady` low: `fetchPc` holds; the queue still drains through pops.
- The queue preserves fetch order; `outPc` values of consecutive pops differ by 4 unless a redirect intervenes.

## Timing
- Reset asserted (asynchronous, immediate):
  - `fetchPc = RESET_PC`, so `imAddress = RESET_PC`.
  - count = 0, so `outValid = 0`.
  - `outPc` and `outInstruction` read as 0 (queue storage is cleared).
- First capture at the first rising edge after reset deasserts (if `imReady`). `outValid` goes high in the following cycle.
- Fetch-to-decode latency: 1 cycle, from the capture edge to the head being visible.
- Throughput: 1 instruction/cycle with `imReady` and `outReady` held high.
- Redirect sampled at edge N:
  - `imAddress = target` during cycle N+1.
  - First redirected instruction has `outValid` in cycle N+2.
  - `outValid = 0` in cycle N+1.
- Back-pressure: once count reaches `QUEUE_DEPTH` with no pop, `imAddress` freezes at the address following the last captured word.
- Reset asserted mid-stream discards all queued entries; no partial state survives.

## Structure
- Shared package (with existing `int_t`):
  - `fetch_entry_t` struct `{int_t pc; int_t word;}`.
  - `RESET_PC_DEFAULT` constant.
  - `PC_STEP = 4` constant.
- One sub-module `fetch_queue`: parameterized circular FIFO of `fetch_entry_t`.
  - Ports: push, pop, flush, head, count.
  - Async active-low reset.
- Top level holds the `fetchPc` register, fire/redirect logic and the output mapping.

## Test plan
- Reset release, `imReady=outReady=1`, memory word at address A = A ^ `32'hA5A5_0000` → `outPc` = `0x3000`, `0x3004`, `0x3008` on consecutive cycles from cycle 2; each `outInstruction` matches.
- `outReady=0` for 5 cycles → count saturates at 2; `imAddress` holds at `0x3008`; head holds `0x3000`. Release → pops `0x3000`, `0x3004`, `0x3008` in order, without gaps or duplicates.
- Queue full, redirect to `0x0000_3101` → next cycle `outValid=0` and `imAddress=0x3100`; next popped `outPc=0x3100`; no stale entries.
- `imReady=0` for 3 cycles with `outReady=1` → queue drains; `outValid` falls; `fetchPc` unchanged; fetch resumes at the held address.
- Redirect to `0xFFFF_FFFC` → outputs `0xFFFF_FFFC`, then `0x0000_0000` (wrap).
- Reset asserted between edges during streaming → `outValid=0` and `imAddress=0x3000` immediately, before the next edge.
